// File: rtl/scarv_cop_cprs_wb_pkg.sv
// Shared definitions for the COP register-file write-back slice:
// FSM encoding, CPRS geometry and register-pair address helpers.
package scarv_cop_cprs_wb_pkg;

  localparam int CPRS_REGS = 16;
  localparam int CPRS_AW   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAIR = 2'd1,
    ST_INIT = 2'd2
  } wb_state_t;

  // A register pair always occupies an even/odd register couple.
  function automatic logic [CPRS_AW-1:0] pair_lo_addr(input logic [CPRS_AW-1:0] addr);
    return addr & 4'hE;
  endfunction

  function automatic logic [CPRS_AW-1:0] pair_hi_addr(input logic [CPRS_AW-1:0] addr);
    return addr | 4'h1;
  endfunction

endpackage

// File: rtl/scarv_cop_cprs_wb_onehot16.sv
// 4-to-16 one-hot decoder with enable; an all-zero output when disabled.
module scarv_cop_onehot16
  import scarv_cop_cprs_wb_pkg::*;
(
  input  logic                 en,
  input  logic [CPRS_AW-1:0]   sel,
  output logic [CPRS_REGS-1:0] dec
);

  // Decode the selected register into its pending bit.
  always_comb begin
    dec = {CPRS_REGS{1'b0}};
    if (en) begin
      dec[sel] = 1'b1;
    end else begin
      dec = {CPRS_REGS{1'b0}};
    end
  end

endmodule

// File: rtl/scarv_cop_cprs_wb.sv
// CPRS write-back driver: stages functional-unit results onto the register
// file write port, splits register-pair results and sequences xc.init clears.
module scarv_cop_cprs_wb
  import scarv_cop_cprs_wb_pkg::*;
#(
  parameter int INIT_TMO = 31,
  parameter bit PAIR_EN  = 1'b1
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  output logic                 g_clk_req,
  input  logic                 init_req,
  output logic                 init_ack,
  output logic                 init_err,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [CPRS_AW-1:0]   wb_addr,
  input  logic [3:0]           wb_wen,
  input  logic                 wb_pair,
  input  logic [31:0]          wb_wdata,
  input  logic [31:0]          wb_wdata_hi,
  output logic                 cprs_init,
  input  logic                 cprs_init_done,
  output logic [3:0]           crd_wen,
  output logic [CPRS_AW-1:0]   crd_addr,
  output logic [31:0]          crd_wdata,
  output logic [CPRS_REGS-1:0] pend_vec
);

  localparam logic [4:0] TMO_LIM = 5'(INIT_TMO);

  wb_state_t            state_r;
  wb_state_t            state_nxt_s;
  logic [3:0]           hi_wen_r;
  logic [CPRS_AW-1:0]   hi_addr_r;
  logic [31:0]          hi_data_r;
  logic [4:0]           tmo_cnt_r;
  logic [4:0]           tmo_nxt_s;
  logic                 tmo_hit_s;
  logic                 armed_r;
  logic                 accept_s;
  logic                 pair_s;
  logic [CPRS_REGS-1:0] pend_stage_s;
  logic [CPRS_REGS-1:0] pend_hold_s;

  assign accept_s  = wb_valid & wb_ready;
  assign pair_s    = PAIR_EN & wb_pair;
  assign tmo_nxt_s = tmo_cnt_r + 5'd1;
  assign tmo_hit_s = (tmo_nxt_s == TMO_LIM);

  // State register.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a staged write must drain before an init may start.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (init_req && armed_r && (crd_wen == 4'd0)) begin
          state_nxt_s = ST_INIT;
        end else if (accept_s && pair_s) begin
          state_nxt_s = ST_PAIR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PAIR: state_nxt_s = ST_IDLE;
      ST_INIT: begin
        if (cprs_init_done || tmo_hit_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    wb_ready  = 1'b0;
    cprs_init = 1'b0;
    if (state_r == ST_IDLE) begin
      wb_ready = !init_req;
    end else begin
      wb_ready = 1'b0;
    end
    if (state_r == ST_INIT) begin
      cprs_init = 1'b1;
    end else begin
      cprs_init = 1'b0;
    end
    g_clk_req = wb_valid | init_req | (|crd_wen) | cprs_init |
                (state_r != ST_IDLE) | init_ack;
  end

  // Write port staging and the held hi half of a pair.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      crd_wen   <= 4'd0;
      crd_addr  <= {CPRS_AW{1'b0}};
      crd_wdata <= 32'd0;
      hi_wen_r  <= 4'd0;
      hi_addr_r <= {CPRS_AW{1'b0}};
      hi_data_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            crd_wen   <= wb_wen;
            crd_addr  <= pair_s ? pair_lo_addr(wb_addr) : wb_addr;
            crd_wdata <= wb_wdata;
            if (pair_s) begin
              hi_wen_r  <= wb_wen;
              hi_addr_r <= pair_hi_addr(wb_addr);
              hi_data_r <= wb_wdata_hi;
            end
          end else begin
            crd_wen <= 4'd0;
          end
        end
        ST_PAIR: begin
          crd_wen   <= hi_wen_r;
          crd_addr  <= hi_addr_r;
          crd_wdata <= hi_data_r;
        end
        default: crd_wen <= 4'd0;
      endcase
    end
  end

  // Init sequencing: timeout counter, ack/err pulses, re-arm on init_req low.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      tmo_cnt_r <= 5'd0;
      init_ack  <= 1'b0;
      init_err  <= 1'b0;
      armed_r   <= 1'b1;
    end else begin
      tmo_cnt_r <= (state_r == ST_INIT) ? tmo_nxt_s : 5'd0;
      init_ack  <= (state_r == ST_INIT) && (cprs_init_done || tmo_hit_s);
      init_err  <= (state_r == ST_INIT) && !cprs_init_done && tmo_hit_s;
      if (state_r == ST_INIT) begin
        armed_r <= 1'b0;
      end else if (!init_req) begin
        armed_r <= 1'b1;
      end
    end
  end

  scarv_cop_onehot16 u_pend_stage (
    .en  (|crd_wen),
    .sel (crd_addr),
    .dec (pend_stage_s)
  );

  scarv_cop_onehot16 u_pend_hold (
    .en  (state_r == ST_PAIR),
    .sel (hi_addr_r),
    .dec (pend_hold_s)
  );

  assign pend_vec = pend_stage_s | pend_hold_s;

endmodule

// File: tb/tb_scarv_cop_cprs_wb.sv
// Bench for scarv_cop_cprs_wb: a write-queue/init-phase reference model is
// compared every cycle, with directed literal checks and randomized traffic.
module tb_scarv_cop_cprs_wb;

  localparam int INIT_TMO = 31;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        g_clk_req;
  logic        init_req = 1'b0;
  logic        init_ack, init_err;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [3:0]  wb_addr = 4'd0;
  logic [3:0]  wb_wen = 4'd0;
  logic        wb_pair = 1'b0;
  logic [31:0] wb_wdata = 32'd0;
  logic [31:0] wb_wdata_hi = 32'd0;
  logic        cprs_init;
  logic        cprs_init_done;
  logic [3:0]  crd_wen, crd_addr;
  logic [31:0] crd_wdata;
  logic [15:0] pend_vec;

  always #5 g_clk = ~g_clk;

  scarv_cop_cprs_wb #(.INIT_TMO(INIT_TMO), .PAIR_EN(1'b1)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(g_clk_req),
    .init_req(init_req), .init_ack(init_ack), .init_err(init_err),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_wen(wb_wen), .wb_pair(wb_pair), .wb_wdata(wb_wdata),
    .wb_wdata_hi(wb_wdata_hi), .cprs_init(cprs_init),
    .cprs_init_done(cprs_init_done), .crd_wen(crd_wen), .crd_addr(crd_addr),
    .crd_wdata(crd_wdata), .pend_vec(pend_vec)
  );

  // CPRS register file model with its clear counter.
  logic [31:0] cprs_regs [16];
  logic [3:0]  ccnt = 4'd0;
  logic        no_done = 1'b0;

  assign cprs_init_done = cprs_init && (ccnt == 4'd15) && !no_done;

  always @(posedge g_clk) begin
    if (cprs_init) begin
      cprs_regs[ccnt] <= 32'd0;
      ccnt <= ccnt + 4'd1;
    end else begin
      ccnt <= 4'd0;
    end
    for (int b = 0; b < 4; b++) begin
      if (crd_wen[b]) cprs_regs[crd_addr][8*b +: 8] <= crd_wdata[8*b +: 8];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: expected write-port contents, queue of held hi writes,
  // init phase with a cycle count.
  typedef struct packed {
    logic [3:0]  wen;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic [3:0]  m_wen = 4'd0, m_addr = 4'd0;
  logic [31:0] m_data = 32'd0;
  wr_t         hi_q[$];
  bit          m_in_init = 1'b0, m_ack = 1'b0, m_err = 1'b0, m_armed = 1'b1;
  int          m_init_cyc = 0;
  bit          check_en = 1'b0;

  function automatic bit model_ready();
    return !m_in_init && (hi_q.size() == 0) && !init_req;
  endfunction

  task automatic model_step();
    bit  rdy;
    bit  was_init;
    wr_t w;
    if (!g_resetn) begin
      m_wen = 4'd0; m_addr = 4'd0; m_data = 32'd0; hi_q.delete();
      m_in_init = 1'b0; m_init_cyc = 0; m_ack = 1'b0; m_err = 1'b0; m_armed = 1'b1;
      return;
    end
    rdy = model_ready();
    was_init = m_in_init;
    m_ack = 1'b0;
    m_err = 1'b0;
    if (m_in_init) begin
      m_wen = 4'd0;
      m_init_cyc++;
      if (cprs_init_done) begin
        m_in_init = 1'b0; m_ack = 1'b1;
      end else if (m_init_cyc == INIT_TMO) begin
        m_in_init = 1'b0; m_ack = 1'b1; m_err = 1'b1;
      end
    end else if (hi_q.size() != 0) begin
      w = hi_q.pop_front();
      m_wen = w.wen; m_addr = w.addr; m_data = w.data;
    end else if (init_req && m_armed && (m_wen == 4'd0)) begin
      m_in_init = 1'b1; m_init_cyc = 0; m_wen = 4'd0;
    end else if (wb_valid && rdy) begin
      m_wen = wb_wen;
      m_data = wb_wdata;
      if (wb_pair) begin
        m_addr = wb_addr & 4'hE;
        w.wen = wb_wen; w.addr = wb_addr | 4'h1; w.data = wb_wdata_hi;
        hi_q.push_back(w);
      end else begin
        m_addr = wb_addr;
      end
    end else begin
      m_wen = 4'd0;
    end
    if (was_init || m_in_init) m_armed = 1'b0;
    else if (!init_req) m_armed = 1'b1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge g_clk) begin
    logic [15:0] one;
    logic [15:0] exp_pend;
    bit          exp_req;
    if (check_en) begin
      one = 16'h0001;
      exp_pend = (m_wen != 4'd0) ? (one << m_addr) : 16'h0000;
      if (hi_q.size() != 0) exp_pend = exp_pend | (one << hi_q[0].addr);
      exp_req = wb_valid | init_req | (m_wen != 4'd0) | m_in_init |
                (hi_q.size() != 0) | m_ack;
      check("wb_ready", 32'(wb_ready), 32'(model_ready()));
      check("cprs_init", 32'(cprs_init), 32'(m_in_init));
      check("init_ack", 32'(init_ack), 32'(m_ack));
      check("init_err", 32'(init_err), 32'(m_err));
      check("crd_wen", 32'(crd_wen), 32'(m_wen));
      if (m_wen != 4'd0) begin
        check("crd_addr", 32'(crd_addr), 32'(m_addr));
        check("crd_wdata", crd_wdata, m_data);
      end
      check("pend_vec", 32'(pend_vec), 32'(exp_pend));
      check("g_clk_req", 32'(g_clk_req), 32'(exp_req));
    end
  end

  task automatic tick();
    @(negedge g_clk);
    #1;
    model_step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic send(input logic [3:0] addr, input logic [3:0] wen, input logic pair,
                      input logic [31:0] lo, input logic [31:0] hi);
    wb_valid = 1'b1; wb_addr = addr; wb_wen = wen; wb_pair = pair;
    wb_wdata = lo; wb_wdata_hi = hi;
  endtask

  int  hi_cnt, ack_cnt, extra;
  bit  got_ack, err_seen;

  initial begin
    // Reset
    tick();
    check_en = 1'b1;
    tick();
    g_resetn = 1'b1;
    #1;
    check("rst_wb_ready", 32'(wb_ready), 32'd1);
    check("rst_crd_wen", 32'(crd_wen), 32'd0);
    check("rst_cprs_init", 32'(cprs_init), 32'd0);

    // Single write
    send(4'd3, 4'hF, 1'b0, 32'hDEADBEEF, 32'd0);
    tick();
    wb_valid = 1'b0;
    check("single_wen", 32'(crd_wen), 32'hF);
    check("single_addr", 32'(crd_addr), 32'd3);
    check("single_data", crd_wdata, 32'hDEADBEEF);
    check("single_pend", 32'(pend_vec), 32'h0008);

    // Register pair
    send(4'd5, 4'hF, 1'b1, 32'h11111111, 32'h22222222);
    tick();
    wb_valid = 1'b0;
    #1;
    check("pair_lo_addr", 32'(crd_addr), 32'd4);
    check("pair_lo_data", crd_wdata, 32'h11111111);
    check("pair_ready", 32'(wb_ready), 32'd0);
    check("pair_pend", 32'(pend_vec), 32'h0030);
    tick();
    check("pair_hi_addr", 32'(crd_addr), 32'd5);
    check("pair_hi_data", crd_wdata, 32'h22222222);

    // Randomized traffic with occasional init requests
    for (int i = 0; i < 600; i++) begin
      wb_valid    = ($urandom_range(0, 3) != 0);
      wb_addr     = 4'($urandom_range(0, 15));
      wb_wen      = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      wb_pair     = ($urandom_range(0, 2) == 0);
      wb_wdata    = $urandom;
      wb_wdata_hi = $urandom;
      if ($urandom_range(0, 29) == 0) init_req = ~init_req;
      tick();
    end
    wb_valid = 1'b0;
    init_req = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    // Fill every register, then clear them with an init
    for (int r = 0; r < 16; r++) begin
      send(4'(r), 4'hF, 1'b0, 32'hA5000000 | 32'(r), 32'd0);
      tick();
    end
    wb_valid = 1'b0;
    tick();
    check("fill_r15", cprs_regs[15], 32'hA500000F);
    init_req = 1'b1;
    hi_cnt = 0; ack_cnt = 0; got_ack = 1'b0; err_seen = 1'b0;
    for (int i = 0; i < 60 && !got_ack; i++) begin
      tick();
      if (cprs_init) hi_cnt++;
      if (init_ack) begin ack_cnt++; got_ack = 1'b1; err_seen = init_err; end
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cprs_init || init_ack) extra++;
    end
    init_req = 1'b0;
    tick();
    check("init_high_cycles", 32'(hi_cnt), 32'd16);
    check("init_ack_count", 32'(ack_cnt), 32'd1);
    check("init_no_err", 32'(err_seen), 32'd0);
    check("init_no_restart", 32'(extra), 32'd0);
    for (int r = 0; r < 16; r++) check("init_reg_clear", cprs_regs[r], 32'd0);

    // Init timeout with done never asserted
    no_done = 1'b1;
    init_req = 1'b1;
    hi_cnt = 0; got_ack = 1'b0; err_seen = 1'b0;
    for (int i = 0; i < 80 && !got_ack; i++) begin
      tick();
      if (cprs_init) hi_cnt++;
      if (init_ack) begin got_ack = 1'b1; err_seen = init_err; end
    end
    init_req = 1'b0;
    no_done = 1'b0;
    tick();
    check("tmo_high_cycles", 32'(hi_cnt), 32'd31);
    check("tmo_ack", 32'(got_ack), 32'd1);
    check("tmo_err", 32'(err_seen), 32'd1);

    // init_req and wb_valid together while a write is staged
    send(4'd7, 4'h3, 1'b0, 32'h12345678, 32'd0);
    tick();
    init_req = 1'b1;
    send(4'd9, 4'hF, 1'b0, 32'hCAFEF00D, 32'd0);
    #1;
    check("stage_init_ready", 32'(wb_ready), 32'd0);
    tick();
    check("stage_drained", 32'(crd_wen), 32'd0);
    check("stage_reg7", cprs_regs[7], 32'h00005678);
    check("stage_not_init", 32'(cprs_init), 32'd0);
    tick();
    check("stage_init_on", 32'(cprs_init), 32'd1);
    wb_valid = 1'b0;
    got_ack = 1'b0;
    for (int i = 0; i < 60 && !got_ack; i++) begin
      tick();
      if (init_ack) got_ack = 1'b1;
    end
    check("stage_init_ack", 32'(got_ack), 32'd1);
    init_req = 1'b0;
    tick();

    // Reset during PAIR drops the hi write
    send(4'd11, 4'hF, 1'b1, 32'h33333333, 32'h44444444);
    tick();
    wb_valid = 1'b0;
    g_resetn = 1'b0;
    tick();
    check("rstpair_wen", 32'(crd_wen), 32'd0);
    check("rstpair_pend", 32'(pend_vec), 32'd0);
    g_resetn = 1'b1;
    tick();
    check("rstpair_no_hi", 32'(crd_wen), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
